rs_slot_alloc: RTL and testbench
================================

// Module: rs_slot_alloc
// PURPOSE
//   Parametrised reservation-station slot allocator and occupancy tracker for the RV052B issue stage.
//   Holds one busy bit per RS entry and grants the lowest-index free slot to dispatch.
//   Frees a slot when execute reports completion, and clears all slots on pipeline flush.
//   Exports busy vector, free count and full/empty to dispatch stall logic.
// PARAMETERS
//   DEPTH   8                 number of RS entries (>=2, power of two)
//   IDX_W   $clog2(DEPTH)     slot index width (derived; do not override)
// PORTS
//   clk          in   1        single clock; all state updates on rising edge
//   rst_n        in   1        reset, asynchronous assert, active-low
//   flush        in   1        synchronous clear of all slots (mispredict/exception)
//   alloc_req    in   1        dispatch requests one slot this cycle
//   alloc_gnt    out  1        slot granted this cycle (combinational)
//   alloc_idx    out  IDX_W    granted slot index (valid only when alloc_gnt=1)
//   rel_valid    in   1        execute releases a slot this cycle
//   rel_idx      in   IDX_W    slot being released
//   busy_vec     out  DEPTH    registered occupancy bitmap, bit i = slot i busy
//   free_cnt     out  IDX_W+1  registered number of free slots, 0..DEPTH
//   full         out  1        registered, busy_vec all ones
//   empty        out  1        registered, busy_vec all zeros
//   err_rel      out  1        sticky: release of a non-busy slot was seen
// BEHAVIOUR
//   Reset (rst_n=0, async): busy_vec=0, free_cnt=DEPTH, full=0, empty=1, err_rel=0.
//   Grant: alloc_gnt = alloc_req & ~full & ~flush; alloc_idx = lowest i with busy_vec[i]=0.
//     Grant and index are combinational from registered busy_vec (same-cycle response).
//     alloc_idx drives 0 when no grant.
//   Update at edge (priority top-down):
//     flush=1 -> busy_vec=0, free_cnt=DEPTH; alloc and release ignored; err_rel unchanged.
//     else: set bit alloc_idx if alloc_gnt; clear bit rel_idx if rel_valid & busy_vec[rel_idx].
//   Release of an idle slot: no state change; err_rel<=1 and stays 1 until reset.
//   Simultaneous alloc+release: both applied. Slots cannot collide without bypass
//     (alloc picks a free slot, release targets a busy one). free_cnt net change 0.
//   free_cnt: -1 on grant only, +1 on valid release only, unchanged on both or neither.
//     Never wraps: range 0..DEPTH.
//   full/empty are recomputed from the next busy_vec (not from free_cnt) and registered with it.
//   Latency: slot released in cycle N is allocatable in cycle N+1 (no bypass build).
//   Reset mid-operation: outstanding grants are lost; dispatch must re-request after reset.
// CONFIGURATION
//   RS_REL_BYPASS_EN defined: when full=1 and a valid release occurs, grant proceeds in the same cycle.
//     alloc_idx=rel_idx; that bit stays 1; free_cnt unchanged.
//     Non-full cycles are unchanged; the priority encoder still picks from busy_vec.
//   Undefined: full=1 forces alloc_gnt=0 regardless of rel_valid.
// STRUCTURE
//   Shared package rs_pkg: localparam RS_DEPTH=8, RS_IDX_W; typedef rs_idx_t (logic [RS_IDX_W-1:0]).
//   Sub-module rs_prio_enc: DEPTH-wide lowest-zero finder.
//     Inputs: busy_vec. Outputs: found, idx. Pure combinational.
//   Top holds busy_vec, free_cnt, full/empty/err_rel registers and update logic.
// TESTING
//   1. Reset, then alloc_req=1 for 8 cycles -> alloc_idx 0..7 in order.
//      busy_vec=8'hFF, full=1, free_cnt=0; 9th cycle alloc_gnt=0.
//   2. Full, rel_valid=1 rel_idx=3 -> next cycle busy_vec=8'hF7, free_cnt=1.
//      alloc_req then grants idx 3.
//   3. busy_vec=8'h0F, same-cycle alloc + release idx 1 -> grant idx 4.
//      Next busy_vec=8'h1D, free_cnt stays 4.
//   4. busy_vec=8'h05, release idx 1 -> busy_vec unchanged, err_rel=1, sticky across 10 cycles.
//   5. busy_vec=8'hAA, flush=1 with alloc_req=1 -> alloc_gnt=0.
//      Next cycle busy_vec=0, empty=1, free_cnt=8.
//   6. RS_REL_BYPASS_EN: full, alloc_req + release idx 6 -> alloc_gnt=1, alloc_idx=6.
//      busy_vec stays 8'hFF. Without the macro: alloc_gnt=0.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared definitions for the reservation-station slot allocator.
package rs_pkg;
  localparam int RS_DEPTH = 8;
  localparam int RS_IDX_W = $clog2(RS_DEPTH);
  typedef logic [RS_IDX_W-1:0] rs_idx_t;
endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-zero finder over the RS busy bitmap; purely combinational.
module rs_prio_enc
  import rs_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] busy_vec,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top so the last hit written is the lowest free index.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_vec[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rs_slot_alloc.sv
// Reservation-station slot allocator and occupancy tracker.
// Build option: RS_REL_BYPASS_EN lets a full RS grant the slot being released that cycle.
module rs_slot_alloc
  import rs_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic             rel_valid,
  input  logic [IDX_W-1:0] rel_idx,
  output logic [DEPTH-1:0] busy_vec,
  output logic [IDX_W:0]   free_cnt,
  output logic             full,
  output logic             empty,
  output logic             err_rel
);

  logic             enc_found;
  logic [IDX_W-1:0] enc_idx;
  logic             rel_hit;
  logic             rel_bad;
  logic             bypass;
  logic [DEPTH-1:0] busy_nxt;
  logic [IDX_W:0]   cnt_nxt;

  rs_prio_enc #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_prio_enc (
    .busy_vec (busy_vec),
    .found    (enc_found),
    .idx      (enc_idx)
  );

  assign rel_hit = rel_valid & busy_vec[rel_idx];
  assign rel_bad = rel_valid & ~busy_vec[rel_idx];

`ifdef RS_REL_BYPASS_EN
  assign bypass = full & rel_hit;
`else
  assign bypass = 1'b0;
`endif

  // enc_found is exactly ~full, since full tracks busy_vec all ones.
  assign alloc_gnt = alloc_req & ~flush & (enc_found | bypass);
  assign alloc_idx = !alloc_gnt ? '0 : (bypass ? rel_idx : enc_idx);

  always_comb begin
    busy_nxt = busy_vec;
    cnt_nxt  = free_cnt;
    if (flush) begin
      busy_nxt = '0;
      cnt_nxt  = (IDX_W+1)'(DEPTH);
    end else begin
      // Clear before set so a bypassed slot ends up busy again.
      if (rel_hit)
        busy_nxt[rel_idx] = 1'b0;
      if (alloc_gnt)
        busy_nxt[alloc_idx] = 1'b1;
      if (alloc_gnt && !rel_hit)
        cnt_nxt = free_cnt - 1'b1;
      else if (rel_hit && !alloc_gnt)
        cnt_nxt = free_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec <= '0;
      free_cnt <= (IDX_W+1)'(DEPTH);
      full     <= 1'b0;
      empty    <= 1'b1;
      err_rel  <= 1'b0;
    end else begin
      busy_vec <= busy_nxt;
      free_cnt <= cnt_nxt;
      full     <= &busy_nxt;
      empty    <= ~|busy_nxt;
      if (!flush && rel_bad)
        err_rel <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rs_slot_alloc.sv
// Directed self-checking bench for rs_slot_alloc (honours RS_REL_BYPASS_EN when defined).
module tb_rs_slot_alloc;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             alloc_req;
  logic             alloc_gnt;
  logic [IDX_W-1:0] alloc_idx;
  logic             rel_valid;
  logic [IDX_W-1:0] rel_idx;
  logic [DEPTH-1:0] busy_vec;
  logic [IDX_W:0]   free_cnt;
  logic             full;
  logic             empty;
  logic             err_rel;

  int checks = 0;
  int errors = 0;

  rs_slot_alloc #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .alloc_req (alloc_req),
    .alloc_gnt (alloc_gnt),
    .alloc_idx (alloc_idx),
    .rel_valid (rel_valid),
    .rel_idx   (rel_idx),
    .busy_vec  (busy_vec),
    .free_cnt  (free_cnt),
    .full      (full),
    .empty     (empty),
    .err_rel   (err_rel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Outputs are registered just after the edge; inputs change then too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req = 1'b0;
    rel_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    idle();
    alloc_req = 1'b1;
    for (int k = 0; k < n; k++) step();
    alloc_req = 1'b0;
  endtask

  task automatic release_one(input int idx);
    idle();
    rel_valid = 1'b1;
    rel_idx   = IDX_W'(idx);
    step();
    rel_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    rel_idx = '0;
    #12;
    chk("rst_busy",  busy_vec, 0);
    chk("rst_free",  free_cnt, 8);
    chk("rst_full",  full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_err",   err_rel, 0);
    rst_n = 1'b1;
    step();

    // 1: fill in index order
    alloc_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("t1_gnt%0d", i), alloc_gnt, 1);
      chk($sformatf("t1_idx%0d", i), alloc_idx, i);
      step();
    end
    #1;
    chk("t1_busy",   busy_vec, 8'hFF);
    chk("t1_full",   full, 1);
    chk("t1_free",   free_cnt, 0);
    chk("t1_gnt9",   alloc_gnt, 0);
    chk("t1_idx9",   alloc_idx, 0);
    alloc_req = 1'b0;

    // 2: release slot 3 from full, then regrant it
    release_one(3);
    chk("t2_busy", busy_vec, 8'hF7);
    chk("t2_free", free_cnt, 1);
    chk("t2_full", full, 0);
    alloc_req = 1'b1;
    #1;
    chk("t2_gnt", alloc_gnt, 1);
    chk("t2_idx", alloc_idx, 3);
    step();
    alloc_req = 1'b0;
    chk("t2_busy2", busy_vec, 8'hFF);

    // 3: simultaneous alloc and release
    do_flush();
    alloc_n(4);
    chk("t3_pre", busy_vec, 8'h0F);
    alloc_req = 1'b1;
    rel_valid = 1'b1;
    rel_idx   = 3'd1;
    #1;
    chk("t3_gnt", alloc_gnt, 1);
    chk("t3_idx", alloc_idx, 4);
    step();
    idle();
    chk("t3_busy", busy_vec, 8'h1D);
    chk("t3_free", free_cnt, 4);

    // 4: release of idle slot is an error and sticky
    do_flush();
    alloc_n(3);
    release_one(1);
    chk("t4_pre",  busy_vec, 8'h05);
    chk("t4_err0", err_rel, 0);
    release_one(1);
    chk("t4_busy", busy_vec, 8'h05);
    chk("t4_free", free_cnt, 6);
    chk("t4_err1", err_rel, 1);
    for (int k = 0; k < 10; k++) step();
    chk("t4_sticky", err_rel, 1);

    // 5: flush wins over alloc
    do_flush();
    alloc_n(8);
    for (int i = 0; i < 8; i += 2) release_one(i);
    chk("t5_pre", busy_vec, 8'hAA);
    flush     = 1'b1;
    alloc_req = 1'b1;
    #1;
    chk("t5_gnt", alloc_gnt, 0);
    step();
    idle();
    chk("t5_busy",  busy_vec, 0);
    chk("t5_empty", empty, 1);
    chk("t5_free",  free_cnt, 8);
    chk("t5_err",   err_rel, 1);

    // 6: release while full with a pending request
    alloc_n(8);
    chk("t6_full", full, 1);
    alloc_req = 1'b1;
    rel_valid = 1'b1;
    rel_idx   = 3'd6;
    #1;
`ifdef RS_REL_BYPASS_EN
    chk("t6_gnt", alloc_gnt, 1);
    chk("t6_idx", alloc_idx, 6);
    step();
    idle();
    chk("t6_busy", busy_vec, 8'hFF);
    chk("t6_free", free_cnt, 0);
`else
    chk("t6_gnt", alloc_gnt, 0);
    step();
    idle();
    chk("t6_busy", busy_vec, 8'hBF);
    chk("t6_free", free_cnt, 1);
`endif

    // async reset mid-operation
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2_busy", busy_vec, 0);
    chk("rst2_err",  err_rel, 0);
    chk("rst2_free", free_cnt, 8);
    rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
